// File: rtl/uart_tx.sv
// Buffered UART transmitter: 8N1 frames, LSB first, with a small byte FIFO
// in front of the shifter so software can queue bytes while a frame is on the line.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | line high, waiting for a queued byte to pop into the shifter
// START_BIT | line low for one bit period
// DATA_BITS | eight data bits, LSB first, one bit period each
// STOP_BIT  | line high for one bit period
// CLEANUP   | one-cycle tx_done pulse, then back to IDLE
module uart_tx #(
    parameter int CLOCKS_PER_BIT = 434,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] data_to_send,
    output logic       ready,
    output logic       outgoing_bit,
    output logic       is_transmitting,
    output logic       tx_done,
    output logic [2:0] debug_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [15:0]   LAST_TICK  = 16'(CLOCKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'b000,
        START_BIT = 3'b001,
        DATA_BITS = 3'b010,
        STOP_BIT  = 3'b011,
        CLEANUP   = 3'b100
    } state_t;

    state_t        state, state_next;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop;

    logic [15:0]   tick, tick_next;
    logic [2:0]    bit_index, bit_index_next;
    logic [7:0]    shift_reg, shift_next;
    logic          bit_next, done_next, busy_next;

    // ready comes straight from the registered count, so a send on the
    // same edge as a pop from a full FIFO is still refused.
    assign ready = (count != FULL_COUNT);
    assign push  = send && ready;

    // FIFO storage; reset does not need to clear the payload.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            fifo_mem[wr_ptr] <= data_to_send;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep count steady.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FSM state and registered line/status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            debug_state     <= IDLE;
            outgoing_bit    <= 1'b1;
            tick            <= '0;
            bit_index       <= '0;
            shift_reg       <= '0;
            tx_done         <= 1'b0;
            is_transmitting <= 1'b0;
        end else begin
            state           <= state_next;
            debug_state     <= state;
            outgoing_bit    <= bit_next;
            tick            <= tick_next;
            bit_index       <= bit_index_next;
            shift_reg       <= shift_next;
            tx_done         <= done_next;
            is_transmitting <= busy_next;
        end
    end

    // Next-state, next line value and FIFO pop decision.
    always_comb begin
        state_next     = state;
        bit_next       = outgoing_bit;
        tick_next      = tick;
        bit_index_next = bit_index;
        shift_next     = shift_reg;
        done_next      = 1'b0;
        pop            = 1'b0;

        case (state)
            IDLE: begin
                bit_next = 1'b1;
                if (count != '0) begin
                    pop            = 1'b1;
                    shift_next     = fifo_mem[rd_ptr];
                    tick_next      = '0;
                    bit_index_next = '0;
                    bit_next       = 1'b0;
                    state_next     = START_BIT;
                end
            end
            START_BIT: begin
                if (tick == LAST_TICK) begin
                    tick_next  = '0;
                    bit_next   = shift_reg[0];
                    state_next = DATA_BITS;
                end else begin
                    tick_next = tick + 16'd1;
                end
            end
            DATA_BITS: begin
                if (tick == LAST_TICK) begin
                    tick_next      = '0;
                    bit_index_next = bit_index + 3'd1;
                    shift_next     = {1'b0, shift_reg[7:1]};
                    if (bit_index == 3'd7) begin
                        bit_next   = 1'b1;
                        state_next = STOP_BIT;
                    end else begin
                        bit_next = shift_reg[1];
                    end
                end else begin
                    tick_next = tick + 16'd1;
                end
            end
            STOP_BIT: begin
                bit_next = 1'b1;
                if (tick == LAST_TICK) begin
                    tick_next  = '0;
                    done_next  = 1'b1;
                    state_next = CLEANUP;
                end else begin
                    tick_next = tick + 16'd1;
                end
            end
            CLEANUP: begin
                bit_next   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                bit_next   = 1'b1;
                tick_next  = '0;
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next == START_BIT) || (state_next == DATA_BITS) ||
                    (state_next == STOP_BIT);
    end

endmodule
